// File: rtl/joy_serial_reader.sv
// Polls a 74HC165-style joystick shift chain: load, shift NBITS bits, then
// publish a whole-frame snapshot of the button lines with a one-cycle strobe.
module joy_serial_reader #(
  parameter int CLK_DIV   = 4,
  parameter int NBITS     = 16,
  parameter int FRAME_GAP = 2,
  parameter bit INVERT    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             joy_data,
  output logic             joy_clk,
  output logic             joy_load_n,
  output logic [NBITS-1:0] joy_state,
  output logic             frame_valid,
  output logic             busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(NBITS);
  localparam int GAP_W = $clog2(FRAME_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(FRAME_GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI
  } state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic [GAP_W-1:0]   r_gap;
  logic [BIT_W-1:0]   r_bitcnt;
  logic [NBITS-1:0]   r_shreg;
  logic [NBITS-1:0]   r_joy_state;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_frame_valid;
  logic               r_joy_clk;
  logic               r_joy_load_n;
  logic               r_busy;

  logic               w_tick;
  logic [GAP_W-1:0]   w_gap_inc;

  assign w_tick    = (r_div == DIV_LAST);
  assign w_gap_inc = (r_gap == GAP_FULL) ? GAP_FULL : r_gap + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // joy_data is asynchronous to clk; only r_sync2 is ever sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= joy_data;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_gap         <= '0;
      r_bitcnt      <= '0;
      r_shreg       <= '0;
      r_joy_state   <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_IDLE: begin
            // Gap counter saturates so a late enable starts on the next tick.
            if (w_gap_inc == GAP_FULL && enable) begin
              r_state <= S_LOAD;
              r_gap   <= '0;
            end else begin
              r_gap <= w_gap_inc;
            end
          end
          S_LOAD: begin
            r_state  <= S_SHIFT_LO;
            r_bitcnt <= '0;
          end
          S_SHIFT_LO: begin
            r_shreg[r_bitcnt] <= r_sync2;
            r_state           <= S_SHIFT_HI;
          end
          S_SHIFT_HI: begin
            if (r_bitcnt == BIT_LAST) begin
              r_state       <= S_IDLE;
              r_joy_state   <= INVERT ? ~r_shreg : r_shreg;
              r_frame_valid <= 1'b1;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
              r_state  <= S_SHIFT_LO;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_joy_clk    <= 1'b0;
      r_joy_load_n <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_joy_clk    <= (r_state == S_SHIFT_HI);
      r_joy_load_n <= (r_state != S_LOAD);
      r_busy       <= (r_state != S_IDLE);
    end
  end

  assign joy_clk     = r_joy_clk;
  assign joy_load_n  = r_joy_load_n;
  assign busy        = r_busy;
  assign frame_valid = r_frame_valid;
  assign joy_state   = r_joy_state;

endmodule

// File: tb/tb_joy_serial_reader.sv
// Bench for joy_serial_reader: a bit-indexed chain model drives joy_data, and a
// per-cycle frame-timeline model predicts every output of two DUTs (INVERT=1/0).
module tb_joy_serial_reader;

  localparam int CD  = 4;
  localparam int NB  = 16;
  localparam int FG  = 2;
  localparam int FRAME_CYC = CD * (1 + 2 * NB);
  // Output-visible delay from a bit's wire slot to its capture: 1 registered
  // output, closing tick, 2-flop synchronizer.
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b1;
  logic joy_data;

  logic          d0_clk, d0_load_n, d0_fv, d0_busy;
  logic [NB-1:0] d0_state;
  logic          d1_clk, d1_load_n, d1_fv, d1_busy;
  logic [NB-1:0] d1_state;

  always #5 clk = ~clk;

  joy_serial_reader #(.CLK_DIV(CD), .NBITS(NB), .FRAME_GAP(FG), .INVERT(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .joy_data(joy_data),
    .joy_clk(d0_clk), .joy_load_n(d0_load_n), .joy_state(d0_state),
    .frame_valid(d0_fv), .busy(d0_busy)
  );

  joy_serial_reader #(.CLK_DIV(CD), .NBITS(NB), .FRAME_GAP(FG), .INVERT(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .joy_data(joy_data),
    .joy_clk(d1_clk), .joy_load_n(d1_load_n), .joy_state(d1_state),
    .frame_valid(d1_fv), .busy(d1_busy)
  );

  // Chain model: wire shows word[idx], idx = joy_clk rises since load.
  logic [NB-1:0] word = 16'h0FA5;
  logic          glitch = 1'b0;
  int            idx = 0;
  logic          wire_bit;

  always @(negedge d0_load_n) idx = 0;
  always @(posedge d0_clk) if (d0_load_n) idx = idx + 1;
  always_comb wire_bit = (idx >= 0 && idx < NB) ? word[idx[3:0]] : 1'b1;
  assign joy_data = wire_bit ^ glitch;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int pos = 0;
  int ref_cyc = 0;
  bit in_frame = 0;
  bit running = 0;
  bit en_d1 = 0;
  bit en_d2 = 0;
  logic [NB-1:0] cap = '0;
  logic [NB-1:0] exp_inv = '0;
  logic [NB-1:0] exp_raw = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // Timeline model, evaluated once per cycle at the falling edge.
  always @(negedge clk) begin
    logic [3:0] exp_ctl;
    bit         e_fv;
    int         j;
    if (!rst_n) begin
      running  = 0;
      in_frame = 0;
      exp_inv  = '0;
      exp_raw  = '0;
      chk("rst_ctl0", {28'd0, d0_load_n, d0_clk, d0_busy, d0_fv}, 32'h8);
      chk("rst_ctl1", {28'd0, d1_load_n, d1_clk, d1_busy, d1_fv}, 32'h8);
      chk("rst_state0", {16'd0, d0_state}, 32'd0);
      chk("rst_state1", {16'd0, d1_state}, 32'd0);
    end else begin
      if (!running) begin
        running = 1; cyc = 0; ref_cyc = 0; en_d1 = 0; en_d2 = 0;
      end else begin
        cyc++;
      end
      if (in_frame) begin
        pos++;
      end else if (((cyc - 1) % CD == 0) && (cyc - ref_cyc >= FG * CD + 1) && en_d2) begin
        in_frame = 1;
        pos = 0;
      end
      e_fv = in_frame && (pos == FRAME_CYC - 1);
      exp_ctl[3] = !(in_frame && pos < CD);
      exp_ctl[2] = in_frame && (pos / CD >= 2) && ((pos / CD) % 2 == 0);
      exp_ctl[1] = in_frame;
      exp_ctl[0] = e_fv;
      if (in_frame && pos >= CD && ((pos + LAT) % (2 * CD)) == 0) begin
        j = (pos + LAT) / (2 * CD) - 1;
        if (j < NB) cap[j] = joy_data;
      end
      if (e_fv) begin
        exp_raw = cap;
        exp_inv = ~cap;
      end
      chk("ctl0{load_n,clk,busy,fv}", {28'd0, d0_load_n, d0_clk, d0_busy, d0_fv}, {28'd0, exp_ctl});
      chk("ctl1{load_n,clk,busy,fv}", {28'd0, d1_load_n, d1_clk, d1_busy, d1_fv}, {28'd0, exp_ctl});
      chk("state_inv", {16'd0, d0_state}, {16'd0, exp_inv});
      chk("state_raw", {16'd0, d1_state}, {16'd0, exp_raw});
      if (e_fv) begin
        in_frame = 0;
        ref_cyc  = cyc;
      end
      en_d2 = en_d1;
      en_d1 = enable;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    do begin step(); n++; end while (!(in_frame && pos == p) && n < 1000);
    chk("wait_pos_reached", {31'd0, (in_frame && pos == p)}, 32'd1);
  endtask

  task automatic wait_fv(output int c);
    int n = 0;
    do begin step(); n++; end while (d0_fv !== 1'b1 && n < 1000);
    chk("wait_fv_reached", {31'd0, d0_fv}, 32'd1);
    c = cyc;
  endtask

  task automatic wait_load(output int c);
    int n = 0;
    do begin step(); n++; end while (d0_load_n !== 1'b0 && n < 1000);
    chk("wait_load_reached", {31'd0, ~d0_load_n}, 32'd1);
    c = cyc;
  endtask

  task automatic pulse_at(input int p);
    wait_pos(p - 1);
    @(posedge clk); #1 glitch = 1'b1;
    @(posedge clk); #1 glitch = 1'b0;
    $display("glitch pulse at frame cycle %0d", p);
  endtask

  initial begin
    int c1, c2, cnt_fv, cnt_ld, n;
    #1 rst_n = 1'b0;
    repeat (3) step();
    drive_slot();
    rst_n = 1'b1;

    // Reset release timing and wire word 0FA5.
    wait_load(c1);
    chk("first_load_cyc", c1, 9);
    $display("first LOAD at cycle %0d", c1);
    wait_fv(c1);
    chk("first_fv_cyc", c1, 140);
    chk("frame1_inv", {16'd0, d0_state}, 32'h0000F05A);
    chk("frame1_raw", {16'd0, d1_state}, 32'h00000FA5);
    $display("frame 1 valid at cycle %0d state %h raw %h", c1, d0_state, d1_state);
    wait_fv(c2);
    chk("fv_period", c2 - c1, 140);
    $display("frame 2 valid at cycle %0d period %0d", c2, c2 - c1);

    // Wire word changes to FFFF between bit 7 and bit 8.
    wait_pos(64);
    drive_slot();
    word = 16'hFFFF;
    wait_pos(100);
    chk("hold_midframe", {16'd0, d0_state}, 32'h0000F05A);
    wait_fv(c1);
    chk("mixed_inv", {16'd0, d0_state}, 32'h0000005A);
    chk("mixed_raw", {16'd0, d1_state}, 32'h0000FFA5);
    $display("mixed frame state %h raw %h", d0_state, d1_state);
    drive_slot();
    word = 16'h1234;

    // enable dropped during bit 5: frame finishes, then no LOAD.
    wait_pos(44);
    drive_slot();
    enable = 1'b0;
    cnt_fv = 0;
    cnt_ld = 0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (d0_fv === 1'b1) cnt_fv++;
      if (d0_load_n === 1'b0) cnt_ld++;
    end
    chk("disable_fv_count", cnt_fv, 1);
    chk("disable_load_count", cnt_ld, 0);
    chk("disable_state", {16'd0, d0_state}, 32'h0000EDCB);
    $display("enable low: %0d frame_valid, %0d load cycles, state %h", cnt_fv, cnt_ld, d0_state);
    drive_slot();
    enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (d0_load_n !== 1'b0 && n < 50);
    chk("reenable_latency_ok", {31'd0, (d0_load_n === 1'b0 && n <= CD + 2)}, 32'd1);
    $display("LOAD %0d cycles after enable rose", n);

    // Asynchronous reset during bit 10 (joy_clk high).
    wait_pos(88);
    drive_slot();
    chk("pre_reset_clk", {31'd0, d0_clk}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", {28'd0, d0_load_n, d0_clk, d0_busy, d0_fv}, 32'h8);
    chk("async_rst_state", {16'd0, d0_state}, 32'd0);
    chk("async_rst_state_raw", {16'd0, d1_state}, 32'd0);
    $display("reset mid-frame: load_n=%b clk=%b state=%h", d0_load_n, d0_clk, d0_state);
    repeat (3) step();
    drive_slot();
    rst_n = 1'b1;
    wait_load(c1);
    chk("post_rst_load_cyc", c1, 9);
    wait_fv(c1);
    chk("post_rst_fv_cyc", c1, 140);
    chk("post_rst_state", {16'd0, d0_state}, 32'h0000EDCB);
    $display("fresh frame after reset at cycle %0d state %h", c1, d0_state);
    drive_slot();
    word = 16'h0000;

    // Glitches: only the pulse two clocks before bit 3's capture lands.
    pulse_at(26);
    pulse_at(28);
    pulse_at(30);
    pulse_at(43);
    pulse_at(45);
    wait_fv(c1);
    chk("glitch_inv", {16'd0, d0_state}, 32'h0000FFF7);
    chk("glitch_raw", {16'd0, d1_state}, 32'h00000008);
    $display("glitch frame state %h raw %h", d0_state, d1_state);

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
